// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: issues READ (0x03) + 24-bit address in SPI mode 0,
// then streams len bytes back through a 1-entry valid/ready output register.
module spi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_req_valid,
  output logic                 io_req_ready,
  input  logic [23:0]          io_req_bits_addr,
  input  logic [LEN_WIDTH-1:0] io_req_bits_len,
  output logic                 io_resp_valid,
  input  logic                 io_resp_ready,
  output logic [7:0]           io_resp_bits,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_spi_sck,
  output logic                 io_spi_cs,
  output logic                 io_spi_mosi,
  input  logic                 io_spi_miso
);

  localparam logic [8:0] HALF_RELOAD = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_RELOAD  = 9'(2 * CLK_DIV - 1);
  localparam logic [7:0] READ_CMD    = 8'h03;

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR, DATA, WAIT_RESP, HOLD, GAP
  } state_t;

  state_t               state_q;
  logic [8:0]           div_q;
  logic [4:0]           bit_q;
  logic [31:0]          shift_q;
  logic [7:0]           rx_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 sck_q;
  logic                 cs_q;
  logic                 mosi_q;
  logic                 resp_valid_q;
  logic [7:0]           resp_bits_q;
  logic                 done_q;

  logic resp_hs;
  logic slot_free;
  logic tick;

  assign resp_hs   = resp_valid_q && io_resp_ready;
  // Output register can take a new byte if empty or being drained this cycle.
  assign slot_free = !resp_valid_q || resp_hs;
  assign tick      = (div_q == 9'd0);

  assign io_req_ready  = (state_q == IDLE);
  assign io_busy       = (state_q != IDLE);
  assign io_done       = done_q;
  assign io_resp_valid = resp_valid_q;
  assign io_resp_bits  = resp_bits_q;
  assign io_spi_sck    = sck_q;
  assign io_spi_cs     = cs_q;
  assign io_spi_mosi   = mosi_q;

  // Transfer sequencer: half-period divider, bit shifting and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_q         <= '0;
      rem_q        <= '0;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bits_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (resp_hs) resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_req_valid) begin
            if (io_req_bits_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= SETUP;
              cs_q    <= 1'b0;
              shift_q <= {READ_CMD, io_req_bits_addr};
              mosi_q  <= READ_CMD[7];
              rem_q   <= io_req_bits_len;
              bit_q   <= '0;
              div_q   <= HALF_RELOAD;
            end
          end
        end
        // First low half-period: MOSI already carries command bit 7.
        SETUP: begin
          if (tick) begin
            sck_q   <= 1'b1;
            div_q   <= HALF_RELOAD;
            state_q <= CMD;
          end else begin
            div_q <= div_q - 9'd1;
          end
        end
        CMD, ADDR, DATA: begin
          if (!tick) begin
            div_q <= div_q - 9'd1;
          end else begin
            div_q <= HALF_RELOAD;
            if (!sck_q) begin
              // Rising edge: sample the flash.
              sck_q <= 1'b1;
              if (state_q == DATA) rx_q <= {rx_q[6:0], io_spi_miso};
            end else begin
              // Falling edge: bit done, present the next MOSI bit.
              sck_q   <= 1'b0;
              bit_q   <= bit_q + 5'd1;
              shift_q <= shift_q << 1;
              mosi_q  <= shift_q[30];
              if (state_q == CMD && bit_q == 5'd7) begin
                state_q <= ADDR;
                bit_q   <= '0;
              end else if (state_q == ADDR && bit_q == 5'd23) begin
                state_q <= DATA;
                bit_q   <= '0;
                mosi_q  <= 1'b0;
              end else if (state_q == DATA) begin
                mosi_q <= 1'b0;
                if (bit_q == 5'd7) begin
                  bit_q <= '0;
                  rem_q <= rem_q - 1'b1;
                  if (slot_free) begin
                    resp_bits_q  <= rx_q;
                    resp_valid_q <= 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) state_q <= HOLD;
                  end else begin
                    // Completed byte parks in rx_q until the consumer drains.
                    state_q <= WAIT_RESP;
                  end
                end
              end
            end
          end
        end
        // SCK parked low; resume with a full low half-period after handshake.
        WAIT_RESP: begin
          if (resp_hs) begin
            resp_bits_q  <= rx_q;
            resp_valid_q <= 1'b1;
            div_q        <= HALF_RELOAD;
            state_q      <= (rem_q == '0) ? HOLD : DATA;
          end
        end
        HOLD: begin
          if (tick) begin
            cs_q    <= 1'b1;
            div_q   <= GAP_RELOAD;
            state_q <= GAP;
          end else begin
            div_q <= div_q - 9'd1;
          end
        end
        // Done is held back until the final byte has left the output register.
        GAP: begin
          if (tick) begin
            if (slot_free) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_q - 9'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural mode-0 READ flash.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [23:0] io_req_bits_addr;
  logic [15:0] io_req_bits_len;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [7:0]  io_resp_bits;
  logic        io_busy;
  logic        io_done;
  logic        io_spi_sck;
  logic        io_spi_cs;
  logic        io_spi_mosi;
  logic        io_spi_miso;

  int checks = 0;
  int errors = 0;

  spi_flash_reader #(.CLK_DIV(2), .LEN_WIDTH(16)) dut (
    .clock(clk), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_bits_addr(io_req_bits_addr), .io_req_bits_len(io_req_bits_len),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits(io_resp_bits), .io_busy(io_busy), .io_done(io_done),
    .io_spi_sck(io_spi_sck), .io_spi_cs(io_spi_cs),
    .io_spi_mosi(io_spi_mosi), .io_spi_miso(io_spi_miso)
  );

  always #5 clk = ~clk;

  // Flash model: captures cmd+addr, drives data bits on falling SCK.
  logic [7:0]  mem [0:255];
  logic [31:0] m_shreg = '0;
  int          m_bitcnt = 0;
  int          sck_rises = 0;
  int          data_mosi_err = 0;

  always @(posedge io_spi_cs) m_bitcnt = 0;

  always @(posedge io_spi_sck) begin
    sck_rises++;
    if (!io_spi_cs) begin
      if (m_bitcnt < 32) m_shreg = {m_shreg[30:0], io_spi_mosi};
      else if (io_spi_mosi) data_mosi_err++;
      m_bitcnt++;
    end
  end

  always @(negedge io_spi_sck) begin
    int idx;
    logic [7:0] a;
    logic [7:0] b;
    if (!io_spi_cs && m_bitcnt >= 32) begin
      idx = m_bitcnt - 32;
      a = m_shreg[7:0] + 8'(idx / 8);
      b = mem[a];
      io_spi_miso = b[7 - (idx % 8)];
    end
  end

  // Response / done monitor, sampled mid-cycle.
  logic [7:0] got[$];
  int done_cnt = 0;
  bit cs_low_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (io_resp_valid && io_resp_ready) got.push_back(io_resp_bits);
      if (io_done) done_cnt++;
      if (!io_spi_cs) cs_low_seen = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    got.delete();
    done_cnt = 0;
    sck_rises = 0;
    data_mosi_err = 0;
    cs_low_seen = 0;
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] l);
    int n;
    n = 0;
    while (!io_req_ready && n < 200) begin
      step();
      n++;
    end
    io_req_valid = 1'b1;
    io_req_bits_addr = a;
    io_req_bits_len = l;
    step();
    io_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (io_done) begin
        ok = 1;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (io_spi_cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", io_spi_cs); end
    checks++; if (io_spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", io_spi_sck); end
    checks++; if (io_spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", io_spi_mosi); end
    checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", io_req_ready); end
    checks++; if (io_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", io_resp_valid); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", io_busy); end
    checks++; if (io_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", io_done); end
    checks++; if (io_resp_bits !== 8'h00) begin errors++; $display("FAIL reset_resp_bits: got %h expected 00", io_resp_bits); end
    $display("reset: cs=%b sck=%b ready=%b", io_spi_cs, io_spi_sck, io_req_ready);
    step();
  endtask

  task automatic test_read4();
    logic [7:0] exp4 [4];
    bit ok;
    exp4 = '{8'h13, 8'h05, 8'hA5, 8'hFF};
    clear_stats();
    io_resp_ready = 1'b1;
    issue(24'h000010, 16'd4);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read4_done_timeout: got 0 expected 1"); end
    checks++; if (m_shreg[31:24] !== 8'h03) begin errors++; $display("FAIL read4_cmd: got %h expected 03", m_shreg[31:24]); end
    checks++; if (m_shreg[23:0] !== 24'h000010) begin errors++; $display("FAIL read4_addr: got %h expected 000010", m_shreg[23:0]); end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL read4_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== exp4[i]) begin errors++; $display("FAIL read4_byte%0d: got %h expected %h", i, got[i], exp4[i]); end
    end
    checks++; if (sck_rises !== 64) begin errors++; $display("FAIL read4_sck_edges: got %0d expected 64", sck_rises); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL read4_done_count: got %0d expected 1", done_cnt); end
    checks++; if (data_mosi_err !== 0) begin errors++; $display("FAIL read4_mosi_data: got %0d expected 0", data_mosi_err); end
    checks++; if (io_spi_cs !== 1'b1) begin errors++; $display("FAIL read4_cs_end: got %b expected 1", io_spi_cs); end
    $display("read addr=000010 len=4 bytes=%0d sck=%0d done=%0d", got.size(), sck_rises, done_cnt);
  endtask

  task automatic test_stall();
    logic [7:0] exp4 [4];
    bit ok;
    int n;
    int viol;
    int rises_at;
    int rises_stall;
    exp4 = '{8'h13, 8'h05, 8'hA5, 8'hFF};
    clear_stats();
    io_resp_ready = 1'b0;
    issue(24'h000010, 16'd4);
    n = 0;
    while (!io_resp_valid && n < 1000) begin
      step();
      n++;
    end
    checks++; if (!io_resp_valid) begin errors++; $display("FAIL stall_first_valid: got 0 expected 1"); end
    viol = 0;
    rises_at = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 40) rises_at = sck_rises;
      if (c >= 40 && (io_spi_sck || io_spi_cs || !io_busy)) viol++;
    end
    rises_stall = sck_rises - rises_at;
    checks++; if (viol !== 0) begin errors++; $display("FAIL stall_sck_cs_low: got %0d bad cycles expected 0", viol); end
    checks++; if (rises_stall !== 0) begin errors++; $display("FAIL stall_sck_edges: got %0d expected 0", rises_stall); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL stall_early_done: got %0d expected 0", done_cnt); end
    step();
    io_resp_ready = 1'b1;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout: got 0 expected 1"); end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== exp4[i]) begin errors++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp4[i]); end
    end
    checks++; if (sck_rises !== 64) begin errors++; $display("FAIL stall_sck_edges_total: got %0d expected 64", sck_rises); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
    $display("stalled read addr=000010 len=4 bytes=%0d sck=%0d done=%0d", got.size(), sck_rises, done_cnt);
  endtask

  task automatic test_len0();
    clear_stats();
    io_resp_ready = 1'b1;
    io_req_valid = 1'b1;
    io_req_bits_addr = 24'h000010;
    io_req_bits_len = 16'd0;
    @(posedge clk);
    #1;
    io_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (io_done !== 1'b1) begin errors++; $display("FAIL len0_done_next: got %b expected 1", io_done); end
    @(negedge clk);
    checks++; if (io_done !== 1'b0) begin errors++; $display("FAIL len0_done_width: got %b expected 0", io_done); end
    repeat (20) step();
    checks++; if (sck_rises !== 0) begin errors++; $display("FAIL len0_sck_edges: got %0d expected 0", sck_rises); end
    checks++; if (cs_low_seen !== 1'b0) begin errors++; $display("FAIL len0_cs_fell: got %b expected 0", cs_low_seen); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len0_done_count: got %0d expected 1", done_cnt); end
    $display("read addr=000010 len=0 sck=%0d done=%0d", sck_rises, done_cnt);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    io_resp_ready = 1'b1;
    issue(24'h000010, 16'd2);
    ok = 0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      io_req_valid = (c == 20 || c == 60);
      io_req_bits_addr = 24'h000000;
      io_req_bits_len = 16'd3;
      if (c == 20) begin
        checks++; if (io_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b expected 0", io_req_ready); end
        checks++; if (io_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", io_busy); end
      end
      @(negedge clk);
      if (io_done) ok = 1;
      step();
    end
    io_req_valid = 1'b0;
    repeat (100) step();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got 0 expected 1"); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
    checks++; if (sck_rises !== 48) begin errors++; $display("FAIL b2b_sck_edges: got %0d expected 48", sck_rises); end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[1] !== 8'h05) begin errors++; $display("FAIL b2b_byte1: got %h expected 05", got[1]); end
    end
    $display("read addr=000010 len=2 with stray requests bytes=%0d done=%0d", got.size(), done_cnt);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_stats();
    io_resp_ready = 1'b1;
    issue(24'h000010, 16'd4);
    n = 0;
    while (got.size() < 1 && n < 1000) begin
      step();
      n++;
    end
    repeat (12) step();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (io_spi_cs !== 1'b1) begin errors++; $display("FAIL rstmid_cs: got %b expected 1", io_spi_cs); end
    checks++; if (io_resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resp_valid: got %b expected 0", io_resp_valid); end
    checks++; if (io_spi_sck !== 1'b0) begin errors++; $display("FAIL rstmid_sck: got %b expected 0", io_spi_sck); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", io_busy); end
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL rstmid_partial_count: got %0d expected 1", got.size()); end
    step();
    reset = 1'b0;
    step();
    clear_stats();
    issue(24'h000000, 16'd1);
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_done_timeout: got 0 expected 1"); end
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", got.size()); end
    if (got.size() == 1) begin
      checks++; if (got[0] !== 8'h5A) begin errors++; $display("FAIL rstmid_byte: got %h expected 5a", got[0]); end
    end
    checks++; if (sck_rises !== 40) begin errors++; $display("FAIL rstmid_sck_edges: got %0d expected 40", sck_rises); end
    $display("reset mid-read, then read addr=000000 len=1 bytes=%0d sck=%0d", got.size(), sck_rises);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    mem[8'h00] = 8'h5A;
    mem[8'h10] = 8'h13;
    mem[8'h11] = 8'h05;
    mem[8'h12] = 8'hA5;
    mem[8'h13] = 8'hFF;
    io_spi_miso = 1'b0;
    io_req_valid = 1'b0;
    io_req_bits_addr = '0;
    io_req_bits_len = '0;
    io_resp_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_read4();
    test_stall();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2, clock cycles per SCK half-period (legal range 1..255).
REQ-002 Parameter LEN_WIDTH, default 16, width of the byte-count field.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_req_valid  in  1  read request present.
REQ-006 io_req_ready  out  1  request accepted when valid&&ready.
REQ-007 io_req_bits_addr  in  24  flash byte address.
REQ-008 io_req_bits_len  in  LEN_WIDTH  byte count to read.
REQ-009 io_resp_valid  out  1  received byte available.
REQ-010 io_resp_ready  in  1  consumer accepts byte.
REQ-011 io_resp_bits  out  8  received byte.
REQ-012 io_busy  out  1  high from request accept until io_done.
REQ-013 io_done  out  1  one-cycle pulse at transfer end.
REQ-014 io_spi_sck  out  1  SPI clock, mode 0 (idle low).
REQ-015 io_spi_cs  out  1  chip select, active low.
REQ-016 io_spi_mosi  out  1  controller-to-flash serial data, MSB first.
REQ-017 io_spi_miso  in  1  flash-to-controller serial data.

Function
REQ-018 States: IDLE, SETUP, CMD, ADDR, DATA, WAIT_RESP, HOLD, GAP.
REQ-019 io_req_ready SHALL be 1 only in IDLE; io_req_valid outside IDLE is ignored and does not queue.
REQ-020 Accept with len==0: no CS assertion, no SCK edges; io_done pulses the cycle after accept; return to IDLE.
REQ-021 Accept with len>0: latch addr/len; next cycle io_spi_cs=0, io_spi_mosi=bit7 of 0x03, enter SETUP for CLK_DIV cycles.
REQ-022 Bit timing: each bit = CLK_DIV cycles SCK low then CLK_DIV cycles SCK high; MOSI changes only in the cycle SCK goes low; MISO sampled in the cycle SCK goes high.
REQ-023 CMD shifts 8 bits of 0x03; ADDR shifts 24 address bits MSB first; MOSI=0 during DATA.
REQ-024 DATA shifts 8 MISO bits per byte MSB first; after the 8th falling edge the byte loads into a 1-entry output register and io_resp_valid=1.
REQ-025 If bytes remain and the output register is empty or being handshaked that cycle, continue DATA without gap; otherwise enter WAIT_RESP holding SCK low, CS low, until handshake, then resume with the next low half-period.
REQ-026 io_resp_valid/io_resp_bits SHALL stay stable until handshake.
REQ-027 After last byte's final falling edge: HOLD for CLK_DIV cycles with CS low, then CS=1 and enter GAP for 2*CLK_DIV cycles; io_done pulses on GAP exit, then IDLE.
REQ-028 io_done SHALL NOT pulse until the last byte has been handshaked; GAP/IDLE transition waits for it.
REQ-029 Remaining-byte counter is LEN_WIDTH wide; max len 2^LEN_WIDTH-1 with no wrap; address counter not required (flash auto-increments).
REQ-030 Total SCK rising edges per transfer = 32 + 8*len exactly.

Reset
REQ-031 Reset (any state, including mid-transfer): io_spi_cs=1, io_spi_sck=0, io_spi_mosi=0, io_resp_valid=0, io_done=0, io_busy=0, io_req_ready=1 in the cycle after reset is sampled; pending byte discarded.
REQ-032 io_resp_bits reset value 0x00; all counters reset to 0.

Verification
REQ-033 Reset 10 cycles -> cs=1, sck=0, mosi=0, req_ready=1, resp_valid=0, busy=0.
REQ-034 CLK_DIV=2, addr=0x000010, len=4, resp_ready=1, flash model preloaded 0x13,0x05,0xA5,0xFF at 0x10 -> MOSI bytes 0x03,0x00,0x00,0x10; resp 0x13,0x05,0xA5,0xFF; 64 SCK rising edges; single io_done pulse.
REQ-035 Same as REQ-034 with resp_ready held 0 for 50 cycles after first resp_valid -> SCK low and CS low throughout stall, all 4 bytes delivered in order, none lost or duplicated.
REQ-036 len=0 request -> cs never falls, zero SCK edges, io_done exactly 1 cycle after accept.
REQ-037 Reset asserted mid-DATA (second byte) -> cs=1 and resp_valid=0 next cycle; subsequent len=1 read at 0x0 returns correct byte.
REQ-038 io_req_valid pulsed while busy -> ignored; exactly one transfer and one io_done observed.
